ysyx_24120013_exu_pipe: RTL and testbench
=========================================

Name: ysyx_24120013_exu_pipe

Overview:
- Parametrised, handshaked execute unit; successor to the single-op, single-cycle EXU.
- Sits between decode (IDU) and register-file writeback.
- Accepts one instruction per valid/ready handshake and executes a 12-op ALU set; MUL runs as an iterative shift-add.
- Holds each result in an output register until writeback accepts it, then emits the register-file write.

Parameters:
- ADDR_WIDTH, 5: register address width.
- DATA_WIDTH, 32: operand/result width; power of two, >= 8.
- IMM_WIDTH, 20: immediate width; must be <= DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  unit can accept an instruction this cycle.
- op  in  4  operation code (see Behaviour).
- use_imm  in  1  1: operand B = sign-extended imm; 0: operand B = src2.
- imm  in  IMM_WIDTH  immediate.
- src1  in  DATA_WIDTH  operand A.
- src2  in  DATA_WIDTH  operand B when use_imm=0.
- des_addr  in  ADDR_WIDTH  destination register.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  writeback accepts the result.
- busy  out  1  high while in state MUL.
- EXU_wen  out  1  register-file write enable.
- EXU_waddr  out  ADDR_WIDTH  write address.
- EXU_wdata  out  DATA_WIDTH  write data.

Behaviour:
- Handshake
  - Accept occurs when in_valid && in_ready at a rising edge; op, use_imm, imm, src1, src2 and des_addr are captured at that edge.
  - Result hand-off occurs when out_valid && out_ready.
- Operand B
  - use_imm=1: imm sign-extended from bit IMM_WIDTH-1 to DATA_WIDTH.
  - use_imm=0: src2.
- op encoding
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = B[$clog2(DATA_WIDTH)-1:0]; upper bits ignored.
  - 8 SLT (signed), 9 SLTU: result is 1 or 0, zero-extended.
  - 10 MUL: low DATA_WIDTH bits of A*B; iterative.
  - 11 PASSB: result = B.
  - 12-15: result 0; otherwise handled like a single-cycle op.
  - All arithmetic wraps modulo 2^DATA_WIDTH.
- FSM states
  - IDLE: in_ready=1.
    - Accept of a non-MUL op -> DONE, result registered.
    - Accept of MUL -> MUL; accumulator cleared, multiplicand and multiplier loaded, counter = DATA_WIDTH-1.
  - MUL: in_ready=0, busy=1.
    - Each cycle: if multiplier LSB set, add multiplicand to accumulator; shift multiplicand left 1 and multiplier right 1; decrement counter.
    - After the step with counter=0 -> DONE with accumulator as result.
  - DONE: out_valid=1; result and address held stable until hand-off.
    - in_ready = out_ready. Hand-off with a simultaneous accept follows the IDLE accept rules (back-to-back allowed).
    - Hand-off without an accept -> IDLE.
- Latency
  - Non-MUL: accept at edge N, out_valid from cycle N+1.
  - MUL: out_valid from cycle N+DATA_WIDTH+1.
  - Throughput: 1 non-MUL op/cycle while out_ready=1.
- Writeback
  - EXU_wen = out_valid && out_ready && (EXU_waddr != 0).
  - des_addr=0 still occupies the pipeline and still hands off, but never writes.
  - EXU_waddr and EXU_wdata are driven from the result register; both are 0 whenever out_valid=0.
- Reset (rst=0)
  - Immediately forces IDLE, including mid-MUL and mid-DONE.
  - Clears all registers and aborts any in-flight result; no write occurs.
  - Outputs during reset: out_valid=0, busy=0, EXU_wen=0, EXU_waddr=0, EXU_wdata=0, in_ready=0.
  - in_ready rises in the first cycle after rst deasserts.
- in_valid while in_ready=0 is ignored; decode must hold it.

Test Plan:
- ADD, use_imm=1, src1=0x0000_0010, imm=0xFFFFF, des_addr=5, out_ready=1 -> next cycle out_valid=1, EXU_wen=1, EXU_waddr=5, EXU_wdata=0x0000_000F.
- Back-to-back SUB 3-5 then SRA 0x8000_0000 by 33, des_addr=1 and 2 -> wdata 0xFFFF_FFFE then 0xC000_0000 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles after XOR 0xF0F0_F0F0^0xFFFF_0000, des_addr=7 -> out_valid stays 1, in_ready=0, wdata stable 0x0F0F_F0F0; EXU_wen pulses once when out_ready rises.
- MUL 0x0001_0003 * 0x0000_0007, des_addr=9 -> busy for 32 cycles, out_valid at cycle N+33, wdata 0x0007_0015; in_valid during busy is not accepted.
- SLT/SLTU with A=0xFFFF_FFFF, B=1, des_addr=0 -> results 1 and 0, hand-off occurs, EXU_wen stays 0.
- Drop rst to 0 midway through a MUL -> busy/out_valid drop immediately, no EXU_wen; after release, ADD 2+2 -> wdata 4 with no stale data.

Source files
------------

// File: rtl/ysyx_24120013_exu_pipe.sv
// Handshaked execute unit: 12-op ALU with iterative shift-add MUL.
// Each result is held in an output register until writeback accepts it.
module ysyx_24120013_exu_pipe #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic                  use_imm,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [ADDR_WIDTH-1:0] des_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  EXU_wen,
  output logic [ADDR_WIDTH-1:0] EXU_waddr,
  output logic [DATA_WIDTH-1:0] EXU_wdata
);

  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] opb;
  logic [DATA_WIDTH-1:0] alu;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_step;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SW-1:0]         cnt;
  logic [SW-1:0]         shamt;
  logic                  accept;
  logic                  hand;
  logic                  is_mul;
  logic                  mul_last;

  assign opb = use_imm ? DATA_WIDTH'($signed(imm)) : src2;
  assign shamt = opb[SW-1:0];
  assign is_mul = (op == 4'd10);
  assign accept = in_valid & in_ready;
  assign hand = out_valid & out_ready;
  assign mul_last = (state == S_MUL) && (cnt == '0);
  assign acc_step = mplier[0] ? acc + mcand : acc;

  always_comb begin
    alu = '0;
    unique case (op)
      4'd0:    alu = src1 + opb;
      4'd1:    alu = src1 - opb;
      4'd2:    alu = src1 & opb;
      4'd3:    alu = src1 | opb;
      4'd4:    alu = src1 ^ opb;
      4'd5:    alu = src1 << shamt;
      4'd6:    alu = src1 >> shamt;
      4'd7:    alu = $signed(src1) >>> shamt;
      4'd8:    alu = {{(DATA_WIDTH-1){1'b0}},
                      $signed(src1) < $signed(opb)};
      4'd9:    alu = {{(DATA_WIDTH-1){1'b0}}, src1 < opb};
      4'd11:   alu = opb;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // An accept in DONE implies a hand-off, so it re-enters via IDLE rules.
  always_comb begin
    state_n = state;
    if (accept)
      state_n = is_mul ? S_MUL : S_DONE;
    else if (mul_last)
      state_n = S_DONE;
    else if ((state == S_DONE) && hand)
      state_n = S_IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: in_ready = rst;
      S_MUL:  busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q  <= '0;
      addr_q <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      addr_q <= des_addr;
      if (is_mul) begin
        acc    <= '0;
        mcand  <= src1;
        mplier <= opb;
        cnt    <= SW'(DATA_WIDTH - 1);
      end else begin
        res_q <= alu;
      end
    end else if (state == S_MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) res_q <= acc_step;
    end
  end

  assign EXU_waddr = out_valid ? addr_q : '0;
  assign EXU_wdata = out_valid ? res_q : '0;
  assign EXU_wen = hand && (EXU_waddr != '0);

endmodule

// File: tb/tb_ysyx_24120013_exu_pipe.sv
// Bench for ysyx_24120013_exu_pipe: directed cases plus random traffic
// checked against an arithmetic reference and an expected-result queue.
module tb_ysyx_24120013_exu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        use_imm;
  logic [19:0] imm;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  des_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        EXU_wen;
  logic [4:0]  EXU_waddr;
  logic [31:0] EXU_wdata;

  ysyx_24120013_exu_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .use_imm   (use_imm),
    .imm       (imm),
    .src1      (src1),
    .src2      (src2),
    .des_addr  (des_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .EXU_wen   (EXU_wen),
    .EXU_waddr (EXU_waddr),
    .EXU_wdata (EXU_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_wen = 0;
  int n_hand = 0;
  bit rnd = 0;
  bit seen = 0;

  logic [4:0]  q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    longint sa, sb;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'(sa / (longint'(1) << sh) -
                        ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return 32'(longint'(a) * longint'(b));
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard: sampled mid-cycle, so handshakes seen here fire at the next edge.
  always @(negedge clk) begin
    logic [31:0] b;
    cyc++;
    if (!rst) begin
      q_addr.delete();
      q_data.delete();
      q_cyc.delete();
      seen = 0;
    end else begin
      if (out_valid) begin
        if (q_addr.size() == 0) begin
          chk("spurious_valid", 64'(q_addr.size()), 64'd1);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc), 64'(q_cyc[0]));
            seen = 1;
          end
          chk("waddr", 64'(EXU_waddr), 64'(q_addr[0]));
          chk("wdata", 64'(EXU_wdata), 64'(q_data[0]));
          if (out_ready) begin
            chk("wen", 64'(EXU_wen), 64'(q_addr[0] != 0));
            n_hand++;
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
            void'(q_cyc.pop_front());
            seen = 0;
          end
        end
      end else begin
        chk("idle_outs", {27'd0, EXU_wen, EXU_waddr, EXU_wdata}, 64'd0);
      end
      if (EXU_wen) n_wen++;
      if (in_valid && in_ready) begin
        b = use_imm ? {{12{imm[19]}}, imm} : src2;
        q_addr.push_back(des_addr);
        q_data.push_back(ref_res(op, src1, b));
        q_cyc.push_back(cyc + 1 + ((op == 4'd10) ? 32 : 0));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [3:0] o, input logic ui,
                      input logic [19:0] im, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] d);
    bit ok = 0;
    int n = 0;
    op = o; use_imm = ui; imm = im;
    src1 = a; src2 = b; des_addr = d;
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 64'(n), 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, h0, nb, n;
    rst = 1'b0; in_valid = 1'b0; op = '0; use_imm = 1'b0;
    imm = '0; src1 = '0; src2 = '0; des_addr = '0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_wen", 64'(EXU_wen), 64'd0);
    chk("rst_waddr", 64'(EXU_waddr), 64'd0);
    chk("rst_wdata", 64'(EXU_wdata), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();

    out_ready = 1'b1;
    send(4'd0, 1'b1, 20'hFFFFF, 32'h10, 32'h0, 5'd5);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_wen", 64'(EXU_wen), 64'd1);
    chk("add_waddr", 64'(EXU_waddr), 64'd5);
    chk("add_wdata", 64'(EXU_wdata), 64'h0000_000F);

    send(4'd1, 1'b0, 20'h0, 32'd3, 32'd5, 5'd1);
    chk("b2b_sub", 64'(EXU_wdata), 64'hFFFF_FFFE);
    send(4'd7, 1'b0, 20'h0, 32'h8000_0000, 32'd33, 5'd2);
    chk("b2b_sra", 64'(EXU_wdata), 64'hC000_0000);
    step();

    out_ready = 1'b0;
    send(4'd4, 1'b0, 20'h0, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd7);
    w0 = n_wen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_wdata", 64'(EXU_wdata), 64'h0F0F_F0F0);
      chk("bp_wen", 64'(EXU_wen), 64'd0);
    end
    step();
    out_ready = 1'b1;
    repeat (3) step();
    chk("bp_wen_pulses", 64'(n_wen - w0), 64'd1);

    send(4'd10, 1'b0, 20'h0, 32'h0001_0003, 32'h7, 5'd9);
    op = 4'd0; src1 = 32'd1; src2 = 32'd1; des_addr = 5'd4;
    in_valid = 1'b1;
    nb = 0; n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (busy) begin
        nb++;
        chk("mul_in_ready", 64'(in_ready), 64'd0);
      end
      if (nb == 10) in_valid = 1'b0;
    end
    chk("mul_busy_cycles", 64'(nb), 64'd32);
    chk("mul_wdata", 64'(EXU_wdata), 64'h0007_0015);
    step();
    step();

    send(4'd8, 1'b0, 20'h0, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("slt_wdata", 64'(EXU_wdata), 64'd1);
    chk("slt_wen", 64'(EXU_wen), 64'd0);
    h0 = n_hand;
    send(4'd9, 1'b0, 20'h0, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("sltu_wdata", 64'(EXU_wdata), 64'd0);
    chk("sltu_wen", 64'(EXU_wen), 64'd0);
    step();
    chk("slt_handoffs", 64'(n_hand - h0), 64'd2);

    send(4'd10, 1'b0, 20'h0, 32'h1234_5678, 32'h9ABC_DEF1, 5'd6);
    repeat (10) step();
    w0 = n_wen;
    rst = 1'b0;
    #1;
    chk("rst_mul_busy", 64'(busy), 64'd0);
    chk("rst_mul_valid", 64'(out_valid), 64'd0);
    chk("rst_mul_wen", 64'(EXU_wen), 64'd0);
    chk("rst_mul_wdata", 64'(EXU_wdata), 64'd0);
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mul_no_write", 64'(n_wen - w0), 64'd0);
    step();
    send(4'd0, 1'b0, 20'h0, 32'd2, 32'd2, 5'd3);
    chk("post_rst_add", 64'(EXU_wdata), 64'd4);
    chk("post_rst_addr", 64'(EXU_waddr), 64'd3);
    step();

    rnd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: b = $urandom_range(0, 40);
        default: ;
      endcase
      send(4'($urandom_range(0, 15)), 1'($urandom), 20'($urandom),
           a, b, 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) step();
    end
    rnd = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n = 0;
    while ((q_addr.size() != 0 || busy) && n < 100) begin
      step();
      n++;
    end
    chk("drain", 64'(q_addr.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
